// File: rtl/delay_ctrl_if.sv
// Avalon-MM slave bus for delay_ctrl: one-cycle strobes, fixed read latency of 1, no waitrequest.
interface delay_ctrl_if;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata
    );
endinterface

// File: rtl/delay_ctrl.sv
// Blinker delay register: key pulses step it, the HPS can write it, and both are clamped to a
// programmable [MIN, MAX] window. Key events are counted and raise a pending interrupt.
module delay_ctrl #(
    parameter int DELAY_W     = 4,
    parameter int RESET_DELAY = 8,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    delay_ctrl_if.slave        avs,
    input  logic               slower,
    input  logic               faster,
    output logic [DELAY_W-1:0] delay,
    output logic               irq
);
    typedef logic [DELAY_W-1:0] dval_t;
    typedef logic [DELAY_W:0]   dext_t;
    typedef logic [CNT_W-1:0]   cnt_t;

    localparam dval_t D_ONE   = dval_t'(1);
    localparam dext_t X_ONE   = dext_t'(1);
    localparam cnt_t  C_ONE   = cnt_t'(1);
    localparam cnt_t  C_MAX   = '1;
    localparam dval_t D_RESET = dval_t'(RESET_DELAY);

    dval_t min_q, max_q, delay_next, wr_val, wr_min, wr_max;
    dext_t up;
    cnt_t  slow_cnt, fast_cnt;
    logic  irq_en, irq_pend;
    logic  wr_delay, wr_lim, wr_evt, wr_irq, lim_ok;
    logic [31:0] rdata;

    function automatic dval_t clamp(dval_t v, dval_t lo, dval_t hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    always_comb begin
        wr_delay = avs.avs_write && (avs.avs_address == 2'd0);
        wr_lim   = avs.avs_write && (avs.avs_address == 2'd1);
        wr_evt   = avs.avs_write && (avs.avs_address == 2'd2);
        wr_irq   = avs.avs_write && (avs.avs_address == 2'd3);
        wr_val   = avs.avs_writedata[DELAY_W-1:0];
        wr_min   = avs.avs_writedata[DELAY_W-1:0];
        wr_max   = avs.avs_writedata[DELAY_W+7:8];
        lim_ok   = (wr_min <= wr_max);
        up       = {1'b0, delay} + X_ONE;

        // A rejected LIMITS write is treated as no write at all, so key steps still apply.
        delay_next = delay;
        if (wr_delay)
            delay_next = clamp(wr_val, min_q, max_q);
        else if (wr_lim && lim_ok)
            delay_next = clamp(delay, wr_min, wr_max);
        else if (slower && !faster)
            delay_next = (up > {1'b0, max_q}) ? max_q : up[DELAY_W-1:0];
        else if (faster && !slower)
            delay_next = (delay <= min_q) ? min_q : delay - D_ONE;
    end

    always_comb begin
        rdata = '0;
        case (avs.avs_address)
            2'd0: rdata[DELAY_W-1:0]   = delay;
            2'd1: begin
                rdata[DELAY_W-1:0]     = min_q;
                rdata[DELAY_W+7:8]     = max_q;
            end
            2'd2: rdata                = {16'(fast_cnt), 16'(slow_cnt)};
            default: rdata[1:0]        = {irq_pend, irq_en};
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            delay            <= D_RESET;
            min_q            <= '0;
            max_q            <= '1;
            slow_cnt         <= '0;
            fast_cnt         <= '0;
            irq_en           <= 1'b0;
            irq_pend         <= 1'b0;
            irq              <= 1'b0;
            avs.avs_readdata <= '0;
        end else begin
            delay <= delay_next;
            if (wr_lim && lim_ok) begin
                min_q <= wr_min;
                max_q <= wr_max;
            end

            // Clear beats a same-cycle increment; counters stick at all-ones.
            if (wr_evt)
                slow_cnt <= '0;
            else if (slower && slow_cnt != C_MAX)
                slow_cnt <= slow_cnt + C_ONE;
            if (wr_evt)
                fast_cnt <= '0;
            else if (faster && fast_cnt != C_MAX)
                fast_cnt <= fast_cnt + C_ONE;

            if (wr_irq)
                irq_en <= avs.avs_writedata[0];
            if (slower || faster)
                irq_pend <= 1'b1;
            else if (wr_irq && avs.avs_writedata[1])
                irq_pend <= 1'b0;

            irq              <= irq_en & irq_pend;
            avs.avs_readdata <= avs.avs_read ? rdata : 32'd0;
        end
    end
endmodule

// File: tb/tb_delay_ctrl.sv
// Bench for delay_ctrl: directed vector table, corner sequences and a randomized run, all
// checked against constants or a register-level behavioural model.
module tb_delay_ctrl;
    localparam int DW = 4;
    localparam int CW = 4;
    localparam int RD = 8;
    localparam int DMASK = (1 << DW) - 1;
    localparam int CMAX  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic slower = 1'b0, faster = 1'b0;
    logic [DW-1:0] delay;
    logic irq;

    delay_ctrl_if bus();

    delay_ctrl #(.DELAY_W(DW), .RESET_DELAY(RD), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .avs(bus.slave),
        .slower(slower), .faster(faster), .delay(delay), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    int m_delay, m_min, m_max, m_slow, m_fast, m_en, m_pend, m_irq;

    typedef struct {
        logic [1:0]  a;
        logic        rd, wr;
        logic [31:0] wd;
        logic        sl, fa;
        logic [3:0]  d;
        logic        iq;
        logic [31:0] rdv;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(logic [1:0] a, logic rd, logic wr, logic [31:0] wd,
                                logic sl, logic fa, logic [3:0] d, logic iq, logic [31:0] rdv);
        vec_t v;
        v.a = a; v.rd = rd; v.wr = wr; v.wd = wd; v.sl = sl; v.fa = fa;
        v.d = d; v.iq = iq; v.rdv = rdv;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_delay = RD; m_min = 0; m_max = DMASK;
        m_slow = 0; m_fast = 0; m_en = 0; m_pend = 0; m_irq = 0;
    endtask

    function automatic logic [31:0] model_read(input int a);
        case (a)
            0: return 32'(m_delay);
            1: return 32'((m_max << 8) | m_min);
            2: return 32'((m_fast << 16) | m_slow);
            default: return 32'((m_pend << 1) | m_en);
        endcase
    endfunction

    // Register-level rules applied once per clock edge.
    task automatic model_edge(input int a, input logic wr, input logic [31:0] wd,
                              input logic sl, input logic fa);
        int nmin, nmax, v;
        bit host;
        host = 0;
        m_irq = m_en & m_pend;
        if (wr && a == 0) begin
            v = int'(wd) & DMASK;
            m_delay = (v < m_min) ? m_min : (v > m_max) ? m_max : v;
            host = 1;
        end else if (wr && a == 1) begin
            nmin = int'(wd) & DMASK;
            nmax = int'(wd >> 8) & DMASK;
            if (nmin <= nmax) begin
                m_min = nmin; m_max = nmax;
                if (m_delay < m_min) m_delay = m_min;
                if (m_delay > m_max) m_delay = m_max;
                host = 1;
            end
        end
        if (!host && sl && !fa) m_delay = (m_delay + 1 > m_max) ? m_max : m_delay + 1;
        if (!host && fa && !sl) m_delay = (m_delay - 1 < m_min) ? m_min : m_delay - 1;
        if (wr && a == 2) begin
            m_slow = 0; m_fast = 0;
        end else begin
            if (sl && m_slow < CMAX) m_slow++;
            if (fa && m_fast < CMAX) m_fast++;
        end
        if (wr && a == 3) m_en = int'(wd[0]);
        if (sl || fa) m_pend = 1;
        else if (wr && a == 3 && wd[1]) m_pend = 0;
    endtask

    task automatic step(input logic [1:0] a, input logic rd, input logic wr,
                        input logic [31:0] wd, input logic sl, input logic fa);
        logic [31:0] exp_rd;
        bus.avs_address = a; bus.avs_read = rd; bus.avs_write = wr;
        bus.avs_writedata = wd; slower = sl; faster = fa;
        exp_rd = model_read(int'(a));
        model_edge(int'(a), wr, wd, sl, fa);
        @(posedge clk); #1;
        bus.avs_read = 1'b0; bus.avs_write = 1'b0; slower = 1'b0; faster = 1'b0;
        chk("model_delay", 32'(delay), 32'(m_delay));
        chk("model_irq", 32'(irq), 32'(m_irq));
        if (rd) chk("model_readdata", bus.avs_readdata, exp_rd);
    endtask

    initial begin
        bus.avs_address = '0; bus.avs_read = 1'b0; bus.avs_write = 1'b0;
        bus.avs_writedata = '0;
        model_reset();

        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(2'(i), 1, 0, 0, 0, 0, 4'd8, 0, (i == 1) ? 32'h0000_0F00 : (i == 0) ? 32'h8 : 32'h0));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(0, 0, 0, 0, 1, 0, (9 + i > 15) ? 4'd15 : 4'(9 + i), 0, 0));
        tbl.push_back(mk(2, 1, 0, 0, 0, 0, 4'd15, 0, 32'h0000_000A));
        tbl.push_back(mk(3, 1, 0, 0, 0, 0, 4'd15, 0, 32'h2));
        tbl.push_back(mk(1, 0, 1, 32'h0603, 0, 0, 4'd6, 0, 0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 0, 0, 0, 0, 1, (5 - i < 3) ? 4'd3 : 4'(5 - i), 0, 0));
        tbl.push_back(mk(1, 0, 1, 32'h0502, 0, 0, 4'd3, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 4'd3, 0, 32'h0502));
        tbl.push_back(mk(1, 0, 1, 32'h0207, 0, 0, 4'd3, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 4'd3, 0, 32'h0502));
        tbl.push_back(mk(1, 0, 1, 32'h0205, 0, 0, 4'd3, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 4'd3, 0, 32'h0502));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 4'd3, 0, 0));
        tbl.push_back(mk(2, 1, 0, 0, 0, 0, 4'd3, 0, 32'h0006_000B));
        tbl.push_back(mk(0, 0, 1, 32'h4, 0, 1, 4'd4, 0, 0));
        tbl.push_back(mk(2, 1, 0, 0, 0, 0, 4'd4, 0, 32'h0007_000B));
        tbl.push_back(mk(3, 0, 1, 32'h1, 0, 0, 4'd4, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'd4, 1, 0));
        tbl.push_back(mk(3, 0, 1, 32'h3, 1, 0, 4'd5, 1, 0));
        tbl.push_back(mk(3, 1, 0, 0, 0, 0, 4'd5, 1, 32'h3));
        tbl.push_back(mk(3, 0, 1, 32'h3, 0, 0, 4'd5, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4'd5, 0, 0));

        #22 reset_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_delay", 32'(delay), 32'h8);
        chk("reset_irq", 32'(irq), 32'h0);
        chk("reset_readdata", bus.avs_readdata, 32'h0);

        foreach (tbl[i]) begin
            step(tbl[i].a, tbl[i].rd, tbl[i].wr, tbl[i].wd, tbl[i].sl, tbl[i].fa);
            chk($sformatf("tbl%0d_delay", i), 32'(delay), 32'(tbl[i].d));
            chk($sformatf("tbl%0d_irq", i), 32'(irq), 32'(tbl[i].iq));
            if (tbl[i].rd) chk($sformatf("tbl%0d_readdata", i), bus.avs_readdata, tbl[i].rdv);
        end

        // Slow counter saturation, then clear racing a pulse.
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 1, 0);
        step(2, 1, 0, 0, 0, 0);
        chk("sat_events", bus.avs_readdata, 32'h0007_000F);
        chk("sat_delay", 32'(delay), 32'h5);
        step(2, 0, 1, 32'hFFFF_FFFF, 1, 0);
        step(2, 1, 0, 0, 0, 0);
        chk("clear_wins", bus.avs_readdata, 32'h0);

        // Reset asserted mid-cycle with a read result on the bus.
        step(0, 1, 0, 0, 0, 0);
        chk("pre_reset_readdata", bus.avs_readdata, 32'h5);
        #2 reset_n = 1'b0;
        #1;
        chk("async_delay", 32'(delay), 32'h8);
        chk("async_irq", 32'(irq), 32'h0);
        chk("async_readdata", bus.avs_readdata, 32'h0);
        @(posedge clk); @(posedge clk); #3 reset_n = 1'b1;
        model_reset();
        step(0, 1, 0, 0, 0, 0); chk("post_reset_a0", bus.avs_readdata, 32'h8);
        step(1, 1, 0, 0, 0, 0); chk("post_reset_a1", bus.avs_readdata, 32'h0000_0F00);
        step(2, 1, 0, 0, 0, 0); chk("post_reset_a2", bus.avs_readdata, 32'h0);
        step(3, 1, 0, 0, 0, 0); chk("post_reset_a3", bus.avs_readdata, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            logic [1:0]  a;
            logic        wr;
            a  = 2'($urandom_range(0, 3));
            wr = ($urandom_range(0, 3) == 0);
            if (a == 2 && $urandom_range(0, 3) != 0) wr = 1'b0;
            step(a, $urandom_range(0, 2) == 0, wr, $urandom,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
